// File: rtl/fetch_unit_if.sv
// Bundle of PC-register, memory-bus, decoder and redirect signals around fetch_unit.
// master: the fetch unit itself; slave: the surrounding PC register, memory and decoder.
interface fetch_unit_if;
  logic        en;
  logic [15:0] pc;
  logic [1:0]  pc_op;
  logic [15:0] pc_in;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic [15:0] imm;
  logic        instr_valid;
  logic        instr_ready;
  logic        flush;
  logic [15:0] flush_target;
  logic        fetch_err;

  modport master (
    input  en, pc, mem_ack, mem_data, instr_ready, flush, flush_target,
    output pc_op, pc_in, mem_rd, mem_addr, instr, imm, instr_valid, fetch_err
  );

  modport slave (
    output en, pc, mem_ack, mem_data, instr_ready, flush, flush_target,
    input  pc_op, pc_in, mem_rd, mem_addr, instr, imm, instr_valid, fetch_err
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads an opcode word plus optional immediate, hands it to the decoder.
// Optional bus timeout enabled by defining FETCH_TIMEOUT_EN.
//
// state     | meaning
// BOOT      | one cycle after reset, commands PC reset
// IDLE      | waiting for en or a flush
// FETCH_OP  | reading the opcode word
// FETCH_IMM | one idle cycle, then reading the immediate word
// HOLD      | instruction presented to decoder
// DRAIN     | flushed while a read was in flight, waiting to discard it
module fetch_unit (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master fu
);

  localparam logic [1:0] PC_NOP   = 2'd0;
  localparam logic [1:0] PC_INC   = 2'd1;
  localparam logic [1:0] PC_SET   = 2'd2;
  localparam logic [1:0] PC_RESET = 2'd3;

  typedef enum logic [2:0] {
    BOOT, IDLE, FETCH_OP, FETCH_IMM, HOLD, DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic        mem_rd_q, mem_rd_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] imm_q, imm_d;
  logic [15:0] tgt_q, tgt_d;
  logic [1:0]  pc_op_d;
  logic [15:0] pc_in_d;
  logic        valid_d;
  logic        timeout;

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] to_cnt_q, to_cnt_d;
  logic       fetch_err_q;

  // Counter reaches 15 on the cycle the read is abandoned.
  assign timeout = mem_rd_q && !fu.mem_ack && (to_cnt_q == 4'd14);

  always_comb begin
    to_cnt_d = 4'd0;
    if (mem_rd_q && !fu.mem_ack) to_cnt_d = to_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q    <= 4'd0;
      fetch_err_q <= 1'b0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      fetch_err_q <= timeout;
    end
  end

  assign fu.fetch_err = fetch_err_q;
`else
  assign timeout      = 1'b0;
  assign fu.fetch_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    mem_rd_d = mem_rd_q;
    instr_d  = instr_q;
    imm_d    = imm_q;
    tgt_d    = tgt_q;
    pc_op_d  = PC_NOP;
    pc_in_d  = tgt_q;
    valid_d  = 1'b0;
    unique case (state_q)
      BOOT: begin
        pc_op_d = PC_RESET;
        state_d = IDLE;
      end
      IDLE: begin
        if (fu.flush) begin
          pc_op_d  = PC_SET;
          pc_in_d  = fu.flush_target;
          state_d  = FETCH_OP;
          mem_rd_d = 1'b1;
        end else if (fu.en) begin
          state_d  = FETCH_OP;
          mem_rd_d = 1'b1;
        end
      end
      FETCH_OP, FETCH_IMM: begin
        if (timeout) begin
          state_d  = IDLE;
          mem_rd_d = 1'b0;
        end else if (fu.flush) begin
          // A read finishing in the flush cycle counts as not outstanding.
          if (!mem_rd_q || fu.mem_ack) begin
            pc_op_d  = PC_SET;
            pc_in_d  = fu.flush_target;
            state_d  = FETCH_OP;
            mem_rd_d = 1'b1;
          end else begin
            tgt_d   = fu.flush_target;
            state_d = DRAIN;
          end
        end else if (!mem_rd_q) begin
          mem_rd_d = 1'b1;
        end else if (fu.mem_ack) begin
          pc_op_d  = PC_INC;
          mem_rd_d = 1'b0;
          if (state_q == FETCH_OP) begin
            instr_d = fu.mem_data;
            if (fu.mem_data[8]) begin
              state_d = FETCH_IMM;
            end else begin
              imm_d   = 16'h0000;
              state_d = HOLD;
            end
          end else begin
            imm_d   = fu.mem_data;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        valid_d = !fu.flush;
        if (fu.flush) begin
          pc_op_d  = PC_SET;
          pc_in_d  = fu.flush_target;
          state_d  = FETCH_OP;
          mem_rd_d = 1'b1;
        end else if (fu.instr_ready) begin
          state_d  = fu.en ? FETCH_OP : IDLE;
          mem_rd_d = fu.en;
        end
      end
      DRAIN: begin
        if (timeout) begin
          state_d  = IDLE;
          mem_rd_d = 1'b0;
        end else if (fu.mem_ack) begin
          pc_op_d = PC_SET;
          pc_in_d = fu.flush ? fu.flush_target : tgt_q;
          state_d = FETCH_OP;
        end else if (fu.flush) begin
          tgt_d = fu.flush_target;
        end
      end
      default: begin
        state_d  = IDLE;
        mem_rd_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      mem_rd_q <= 1'b0;
      instr_q  <= 16'h0000;
      imm_q    <= 16'h0000;
      tgt_q    <= 16'h0000;
    end else begin
      state_q  <= state_d;
      mem_rd_q <= mem_rd_d;
      instr_q  <= instr_d;
      imm_q    <= imm_d;
      tgt_q    <= tgt_d;
    end
  end

  // State sits in BOOT throughout reset, but the PC reset command must wait for release.
  assign fu.pc_op       = rst_n ? pc_op_d : PC_NOP;
  assign fu.pc_in       = pc_in_d;
  assign fu.mem_rd      = mem_rd_q;
  assign fu.mem_addr    = fu.pc;
  assign fu.instr       = instr_q;
  assign fu.imm         = imm_q;
  assign fu.instr_valid = valid_d;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port en  input  1  fetch enable, gates the start of new memory reads only.
REQ-004 SHALL have port pc  input  16  current program counter from the PC register.
REQ-005 SHALL have port pc_op  output  2  PC command (`PC_NOP/`PC_INC/`PC_SET/`PC_RESET encodings from cpu_constants.vh).
REQ-006 SHALL have port pc_in  output  16  PC load value, meaningful only when pc_op=`PC_SET.
REQ-007 SHALL have port mem_rd  output  1  memory read request, held high until mem_ack.
REQ-008 SHALL have port mem_addr  output  16  read address, equal to pc while mem_rd=1.
REQ-009 SHALL have port mem_ack  input  1  read complete, mem_data valid this cycle.
REQ-010 SHALL have port mem_data  input  16  read data.
REQ-011 SHALL have port instr, imm  output  16 each  fetched opcode word and immediate word (imm=0 if none).
REQ-012 SHALL have port instr_valid  output  1 / instr_ready  input  1  valid/ready handshake to decoder.
REQ-013 SHALL have port flush  input  1 / flush_target  input  16  single-cycle branch redirect.
REQ-014 SHALL have port fetch_err  output  1  bus timeout flag (see REQ-031).

Function
REQ-015 States SHALL be BOOT, IDLE, FETCH_OP, FETCH_IMM, HOLD, DRAIN.
REQ-016 BOOT SHALL last exactly one cycle after reset release, drive pc_op=`PC_RESET, then go to IDLE.
REQ-017 IDLE SHALL go to FETCH_OP when en=1; mem_rd SHALL rise in the FETCH_OP entry cycle.
REQ-018 On mem_ack in FETCH_OP: latch mem_data into instr, drive pc_op=`PC_INC that same cycle, deassert mem_rd next cycle.
REQ-019 If latched instr[8]=1, SHALL go to FETCH_IMM (read at incremented pc); else clear imm and go to HOLD.
REQ-020 On mem_ack in FETCH_IMM: latch mem_data into imm, drive pc_op=`PC_INC, go to HOLD.
REQ-021 HOLD SHALL assert instr_valid; instr/imm SHALL be stable until instr_valid&&instr_ready.
REQ-022 On handshake: go to FETCH_OP if en=1, else IDLE; instr_valid low next cycle.
REQ-023 Fetch latency: instr_valid SHALL rise the cycle after the last mem_ack (zero-wait memory: 2 cycles per 1-word, 4 per 2-word instruction, back-to-back).
REQ-024 pc_op SHALL be `PC_NOP in every cycle not covered by REQ-016/018/020/025/026.
REQ-025 flush with no read outstanding: pc_op=`PC_SET, pc_in=flush_target that cycle, drop instr_valid, go to FETCH_OP.
REQ-026 flush with read outstanding (mem_rd=1, no ack): latch target, go to DRAIN; keep mem_rd until ack; on ack discard data, drive `PC_SET with latched target, go to FETCH_OP.
REQ-027 flush coincident with mem_ack: flush SHALL win; `PC_SET driven, `PC_INC suppressed, data discarded.
REQ-028 Second flush while in DRAIN SHALL overwrite latched target.
REQ-029 en=0 SHALL never abort an outstanding read; it only prevents the next read starting.

Reset
REQ-030 rst_n=0 SHALL immediately force state=BOOT, mem_rd=0, instr_valid=0, instr=imm=pc_in=0, pc_op=`PC_NOP, fetch_err=0, timeout counter=0; reset mid-read abandons the read.

Configuration
REQ-031 With FETCH_TIMEOUT_EN defined: 4-bit counter counts cycles with mem_rd=1 and no ack; at 15 SHALL drop mem_rd, pulse fetch_err one cycle, go to IDLE, pc_op=`PC_NOP.
REQ-032 Without FETCH_TIMEOUT_EN: no counter, fetch_err tied 0, reads wait indefinitely.

Verification
REQ-033 Reset release -> pc_op=`PC_RESET for exactly one cycle, then `PC_NOP, mem_rd=0 until en=1.
REQ-034 pc=0x0010, mem_data=0x1200 acked immediately, instr_ready=1 -> instr=0x1200, imm=0, one `PC_INC, instr_valid 1 cycle after ack.
REQ-035 mem_data=0x0100 then 0xBEEF -> two `PC_INC pulses, instr=0x0100, imm=0xBEEF, mem_addr 0x0010 then 0x0012.
REQ-036 flush_target=0x0200 while mem_rd high, ack 3 cycles later -> no `PC_INC, one `PC_SET with pc_in=0x0200, no instr_valid for discarded word.
REQ-037 instr_ready=0 for 5 cycles in HOLD -> instr_valid, instr, imm stable, mem_rd=0, pc_op=`PC_NOP throughout.
REQ-038 FETCH_TIMEOUT_EN defined, mem_ack never -> mem_rd drops after 15 cycles, fetch_err one-cycle pulse, state IDLE.
